// File: rtl/datapath_if.sv
// Control/data bundle between the controller and the datapath.
// There is no handshake: the control word is a plain per-cycle bundle,
// sampled by the datapath on every rising clock edge.
// master = controller side (drives control + memory read data),
// slave  = datapath side (drives register read values, ALU result, zero flag).
interface datapath_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              RF_s;
   logic [ADDR_W-1:0] RF_W_addr;
   logic              RF_W_en;
   logic [ADDR_W-1:0] RF_Ra_addr;
   logic [ADDR_W-1:0] RF_Rb_addr;
   logic [2:0]        ALU_s;
   logic [DATA_W-1:0] mem_rd_data;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] Ra_data;
   logic [DATA_W-1:0] Rb_data;
   logic [DATA_W-1:0] alu_out;
   logic              zero_flag;

   modport master (
      output RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s, mem_rd_data,
      input  mem_wr_data, Ra_data, Rb_data, alu_out, zero_flag
   );

   modport slave (
      input  RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s, mem_rd_data,
      output mem_wr_data, Ra_data, Rb_data, alu_out, zero_flag
   );
endinterface

// File: rtl/datapath.sv
// Execution half of the processor: 2**ADDR_W-entry register file with two
// combinational read ports, 8-function ALU, write-back mux (memory vs ALU)
// and a registered zero flag updated only by ALU write-backs.
// Optional feature: define DATAPATH_RF_BYPASS_EN to forward load (RF_s=1)
// write-back data onto a read port addressing the register being written.
// ALU write-backs are never forwarded, which keeps the ALU out of a loop.
module datapath #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input logic         clk,
   input logic         n_rst,
   datapath_if.slave   bus
);
   localparam int N_REGS = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   logic [DATA_W-1:0] regs_q [N_REGS];
   logic [DATA_W-1:0] regs_d [N_REGS];
   logic              zero_q;
   logic              zero_d;
   logic [DATA_W-1:0] ra_val;
   logic [DATA_W-1:0] rb_val;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] wb_val;

   // Read ports: stored contents, optionally overridden by an in-flight load.
   always_comb begin
      ra_val = regs_q[bus.RF_Ra_addr];
      rb_val = regs_q[bus.RF_Rb_addr];
`ifdef DATAPATH_RF_BYPASS_EN
      if (bus.RF_W_en && bus.RF_s && (bus.RF_Ra_addr == bus.RF_W_addr)) begin
         ra_val = bus.mem_rd_data;
      end
      if (bus.RF_W_en && bus.RF_s && (bus.RF_Rb_addr == bus.RF_W_addr)) begin
         rb_val = bus.mem_rd_data;
      end
`else
      // Without forwarding, a write becomes visible on the next cycle only.
`endif
   end

   // ALU: all results wrap modulo 2**DATA_W, no carry or overflow out.
   always_comb begin
      alu_res = ra_val;
      case (bus.ALU_s)
         3'd0: alu_res = ra_val;
         3'd1: alu_res = ra_val + rb_val;
         3'd2: alu_res = ra_val - rb_val;
         3'd3: alu_res = ra_val & rb_val;
         3'd4: alu_res = ra_val | rb_val;
         3'd5: alu_res = ra_val ^ rb_val;
         3'd6: alu_res = ~ra_val;
         3'd7: alu_res = ra_val + ONE;
      endcase
   end

   // Write-back selection and next-state for register file and zero flag.
   always_comb begin
      wb_val = bus.RF_s ? bus.mem_rd_data : alu_res;
      regs_d = regs_q;
      zero_d = zero_q;
      if (bus.RF_W_en) begin
         regs_d[bus.RF_W_addr] = wb_val;
         if (!bus.RF_s) begin
            zero_d = (alu_res == '0);
         end
      end
   end

   // State registers; asynchronous reset clears every register and the flag.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs_q[i] <= '0;
         end
         zero_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         zero_q <= zero_d;
      end
   end

   assign bus.Ra_data     = ra_val;
   assign bus.Rb_data     = rb_val;
   assign bus.mem_wr_data = ra_val;
   assign bus.alu_out     = alu_res;
   assign bus.zero_flag   = zero_q;
endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios followed by random
// control words, all checked against an array-based register model.
module tb_datapath;
   logic clk;
   logic n_rst;

   datapath_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   datapath #(.DATA_W(16), .ADDR_W(4)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state
   logic [15:0] model_regs [16];
   logic        model_zero;
   int          n_vec;
   int          n_err;

   function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      case (op)
         3'd0: return a;
         3'd1: return 16'((ia + ib) % 65536);
         3'd2: return 16'((ia - ib + 65536) % 65536);
         3'd3: return a & b;
         3'd4: return a | b;
         3'd5: return a ^ b;
         3'd6: return 16'(65535 - ia);
         default: return 16'((ia + 1) % 65536);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) model_regs[i] = 16'h0000;
      model_zero = 1'b0;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver: apply one control word, check outputs before the edge, then clock it
   task automatic apply(input logic s, input logic [3:0] w, input logic wen,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [2:0] op, input logic [15:0] mem);
      logic [15:0] exp_a;
      logic [15:0] exp_b;
      logic [15:0] exp_alu;
      logic [15:0] wb;
      @(negedge clk);
      bus.RF_s        = s;
      bus.RF_W_addr   = w;
      bus.RF_W_en     = wen;
      bus.RF_Ra_addr  = ra;
      bus.RF_Rb_addr  = rb;
      bus.ALU_s       = op;
      bus.mem_rd_data = mem;
      #1;
      exp_a = model_regs[ra];
      exp_b = model_regs[rb];
`ifdef DATAPATH_RF_BYPASS_EN
      if (wen && s && ra == w) exp_a = mem;
      if (wen && s && rb == w) exp_b = mem;
`endif
      exp_alu = alu_ref(exp_a, exp_b, op);
      check("ra_data", bus.Ra_data, exp_a);
      check("rb_data", bus.Rb_data, exp_b);
      check("mem_wr_data", bus.mem_wr_data, exp_a);
      check("alu_out", bus.alu_out, exp_alu);
      check("zero_flag", {15'd0, bus.zero_flag}, {15'd0, model_zero});
      @(posedge clk);
      if (wen) begin
         wb = s ? mem : exp_alu;
         model_regs[w] = wb;
         if (!s) model_zero = (wb == 16'h0000);
      end
   endtask

   task automatic load(input logic [3:0] addr, input logic [15:0] val);
      apply(1'b1, addr, 1'b1, 4'd0, 4'd0, 3'd0, val);
   endtask

   // read-only step; leaves Ra/Rb on the requested registers for direct checks
   task automatic peek(input logic [3:0] ra, input logic [3:0] rb);
      apply(1'b0, 4'd0, 1'b0, ra, rb, 3'd0, 16'h0000);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      n_rst = 1'b0;
      bus.RF_s = 1'b0;
      bus.RF_W_addr = 4'd0;
      bus.RF_W_en = 1'b0;
      bus.RF_Ra_addr = 4'd0;
      bus.RF_Rb_addr = 4'd0;
      bus.ALU_s = 3'd0;
      bus.mem_rd_data = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ra", bus.Ra_data, 16'h0000);
      check("rst_alu", bus.alu_out, 16'h0000);
      check("rst_zero", {15'd0, bus.zero_flag}, 16'h0000);
      n_rst = 1'b1;

      // mid-cycle reset: R5=BEEF and zero_flag=1 beforehand
      apply(1'b0, 4'd7, 1'b1, 4'd0, 4'd0, 3'd2, 16'h0000);
      load(4'd5, 16'hBEEF);
      peek(4'd5, 4'd7);
      check("r5_beef", bus.Ra_data, 16'hBEEF);
      check("zero_before_rst", {15'd0, bus.zero_flag}, 16'h0001);
      @(negedge clk);
      bus.RF_s = 1'b0;
      bus.RF_W_en = 1'b1;
      bus.RF_W_addr = 4'd5;
      bus.RF_Ra_addr = 4'd5;
      bus.ALU_s = 3'd7;
      #2 n_rst = 1'b0;
      #1;
      check("async_rst_ra", bus.Ra_data, 16'h0000);
      check("async_rst_zero", {15'd0, bus.zero_flag}, 16'h0000);
      model_reset();
      @(posedge clk);
      #1;
      check("rst_discards_write", bus.Ra_data, 16'h0000);
      @(negedge clk);
      n_rst = 1'b1;
      bus.RF_W_en = 1'b0;

      // load
      load(4'd3, 16'h1234);
      peek(4'd3, 4'd0);
      check("load_r3", bus.Ra_data, 16'h1234);
      check("load_zero", {15'd0, bus.zero_flag}, 16'h0000);

      // add / sub
      load(4'd1, 16'd5);
      load(4'd2, 16'd7);
      apply(1'b0, 4'd4, 1'b1, 4'd1, 4'd2, 3'd1, 16'h0000);
      peek(4'd4, 4'd0);
      check("add_r4", bus.Ra_data, 16'h000C);
      check("add_zero", {15'd0, bus.zero_flag}, 16'h0000);
      load(4'd6, 16'd5);
      apply(1'b0, 4'd8, 1'b1, 4'd1, 4'd6, 3'd2, 16'h0000);
      load(4'd10, 16'h0001);
      peek(4'd8, 4'd10);
      check("sub_r8", bus.Ra_data, 16'h0000);
      check("zero_held_by_load", {15'd0, bus.zero_flag}, 16'h0001);

      // wrap
      load(4'd1, 16'hFFFF);
      apply(1'b0, 4'd2, 1'b1, 4'd1, 4'd0, 3'd7, 16'h0000);
      peek(4'd2, 4'd0);
      check("inc_wrap", bus.Ra_data, 16'h0000);
      check("inc_wrap_zero", {15'd0, bus.zero_flag}, 16'h0001);
      load(4'd1, 16'h0000);
      load(4'd2, 16'h0001);
      apply(1'b0, 4'd3, 1'b1, 4'd1, 4'd2, 3'd2, 16'h0000);
      peek(4'd3, 4'd0);
      check("sub_wrap", bus.Ra_data, 16'hFFFF);
      check("sub_wrap_zero", {15'd0, bus.zero_flag}, 16'h0000);

      // write disable
      repeat (3) apply(1'b0, 4'd4, 1'b0, 4'd1, 4'd2, 3'd1, 16'h0000);
      peek(4'd4, 4'd0);
      check("wdis_r4", bus.Ra_data, 16'h000C);

      // load forwarding on read port A
      load(4'd9, 16'h0042);
      apply(1'b1, 4'd9, 1'b1, 4'd9, 4'd9, 3'd0, 16'h00A5);
      peek(4'd9, 4'd0);
      check("bypass_after", bus.Ra_data, 16'h00A5);

      // register 0 is writable
      load(4'd0, 16'h5A5A);
      peek(4'd0, 4'd0);
      check("r0_writable", bus.Ra_data, 16'h5A5A);

      // random control words
      for (int i = 0; i < 400; i++) begin
         apply(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom));
      end
      for (int r = 0; r < 16; r++) peek(4'(r), 4'(15 - r));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
